imem_loader_responder: RTL and testbench
========================================

# imem_loader_responder

Instruction-memory responder on the far side of the fetch stage's `imem_addr`/`imem_data` interface. It owns the instruction word array and serves combinational reads to the fetch stage. It also implements a byte-serial program loader: incoming bytes are assembled into words and written sequentially into the array, and the image is verified with an XOR checksum. While a load is in progress the block asserts `imem_busy`, which the hazard unit ORs into the fetch stall, and returns NOPs to the fetch stage.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width; only 32 is supported.
- `IMEM_DEPTH`, 1024, number of words in the array.
- `IMEM_ADDR_WIDTH`, 10, log2(`IMEM_DEPTH`).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  reset.
- Fetch side:
  - `imem_addr`  in  `IMEM_ADDR_WIDTH`  word address from the fetch stage.
  - `imem_data`  out  32  instruction word; combinational.
  - `imem_busy`  out  1  load in progress; fetch must stall.
- Loader side:
  - `load_start`  in  1  begin a load; sampled only in RUN.
  - `load_word_count`  in  `IMEM_ADDR_WIDTH`+1  number of words to load; captured at `load_start`.
  - `load_byte`  in  8  data byte.
  - `load_byte_valid`  in  1  byte present.
  - `load_byte_ready`  out  1  byte accepted when valid&&ready.
  - `load_done`  out  1  one-cycle pulse at the end of a load.
  - `load_error`  out  1  sticky error flag; cleared by the next accepted `load_start` or by reset.

## Operation
States:
- RUN: `imem_data` = mem[`imem_addr`]. `imem_busy`=0. `load_byte_ready`=0.
  - `load_start`=1 with count ≤ `IMEM_DEPTH`: capture the count, clear the word pointer, byte index, accumulator and `load_error`. Go to LOAD, or to CHK if count=0.
  - `load_start`=1 with count > `IMEM_DEPTH`: set `load_error`=1 and stay in RUN; no write occurs.
- LOAD: `load_byte_ready`=1, `imem_busy`=1, `imem_data`=32'h00000013.
  - Bytes are assembled little-endian: byte index 0 → bits [7:0], up to index 3 → bits [31:24].
  - On the 4th accepted byte: write the word to mem[ptr], XOR it into the accumulator, ptr++ and clear the byte index.
  - If ptr+1 == count, go to CHK.
- CHK: `load_byte_ready`=1 and busy as in LOAD. Four bytes are assembled the same way into the checksum word.
  - On the 4th byte: set `load_error` = (checksum ≠ accumulator), pulse `load_done`, go to RUN.
  - Words already written are kept even when the checksum mismatches.

Rules:
- `load_start` is ignored in LOAD and CHK.
- The pointer never exceeds count−1, so there is no wrap-around.
- No write ever happens in RUN, so there is no read/write collision on the fetch port.
- Cycles with `load_byte_valid`=0 make no progress and change no state.
- The memory array is not reset. Its contents are defined only by loads.

## Timing
- Reset values: state=RUN, `imem_busy`=0, `load_byte_ready`=0, `load_done`=0, `load_error`=0, ptr, byte index and accumulator = 0.
- `imem_data` is mem[`imem_addr`] after reset (undefined until the first load).
- Reset mid-load: the next cycle is in RUN. The partial word is discarded. Words already written are retained. `load_done` is not pulsed.
- Reset asserted together with `load_start`: reset wins.
- `imem_busy` and `load_byte_ready` rise in the cycle after the edge that samples `load_start`.
- A word write takes effect at the edge that accepts its 4th byte. The word is readable by the fetch stage once state returns to RUN.
- `load_done` is high for exactly the one cycle after the edge that accepts the 4th checksum byte. In that same cycle:
  - `imem_busy`=0.
  - `load_error` is valid.
  - `imem_data` is the array contents.
- Maximum throughput is one byte per cycle. An N-word load takes at least 4N+4 cycles of accepted bytes.

## Test plan
- Reset, then load with count=2. Bytes 93 00 50 00 13 01 A0 00, checksum bytes 80 01 F0 00 (0x00F00180). Required: one `load_done` pulse, `load_error`=0, `imem_addr`=0 → 0x00500093, `imem_addr`=1 → 0x00A00113.
- Same load with checksum bytes 00 00 00 00. Required: `load_error`=1 and stays 1 until the next `load_start`; both words are still readable.
- During a load, hold `load_byte_valid` low for 3 cycles between bytes. Required: `imem_busy`=1, `imem_data`=0x00000013, no progress during the gap, and the final contents are correct.
- `load_start` with count=1025. Required: `load_error`=1 the next cycle, `imem_busy`=0, `load_byte_ready`=0, and the array is unchanged.
- Assert `rst` after 5 bytes of a 2-word load. Required: the next cycle has `imem_busy`=0, `load_error`=0, no `load_done`, and word 0 is retained.
- `load_start` with count=0, followed by checksum bytes 00 00 00 00. Required: `load_done` pulses after the 4 bytes, `load_error`=0, and the array is unchanged.

Source files
------------

// File: rtl/imem_loader_responder.sv
// Instruction memory responder: combinational fetch reads plus a byte-serial program loader
// that assembles little-endian words, writes them sequentially and verifies an XOR checksum.
module imem_loader_responder #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned IMEM_DEPTH      = 1024,
  parameter int unsigned IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]      imem_data,
  output logic                       imem_busy,
  input  logic                       load_start,
  input  logic [IMEM_ADDR_WIDTH:0]   load_word_count,
  input  logic [7:0]                 load_byte,
  input  logic                       load_byte_valid,
  output logic                       load_byte_ready,
  output logic                       load_done,
  output logic                       load_error
);

  typedef enum logic [1:0] {StRun, StLoad, StChk} state_e;

  localparam logic [DATA_WIDTH-1:0]      Nop    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [IMEM_ADDR_WIDTH:0]   DepthW = (IMEM_ADDR_WIDTH + 1)'(IMEM_DEPTH);
  localparam logic [IMEM_ADDR_WIDTH:0]   OneW   = (IMEM_ADDR_WIDTH + 1)'(1);

  state_e                     state_q, state_d;
  logic [IMEM_ADDR_WIDTH:0]   count_q, count_d;
  logic [IMEM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [1:0]                 byte_idx_q, byte_idx_d;
  logic [23:0]                asm_q, asm_d;
  logic [DATA_WIDTH-1:0]      acc_q, acc_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;

  logic [DATA_WIDTH-1:0]      mem [IMEM_DEPTH];

  logic                       start_ok, start_bad, byte_fire, last_byte, mem_we;
  logic [DATA_WIDTH-1:0]      word_full;
  logic [IMEM_ADDR_WIDTH:0]   ptr_next;

  assign start_ok  = load_start && (load_word_count <= DepthW);
  assign start_bad = load_start && (load_word_count > DepthW);
  assign byte_fire = load_byte_valid && load_byte_ready;
  assign last_byte = byte_fire && (byte_idx_q == 2'd3);
  assign word_full = {load_byte, asm_q};
  assign ptr_next  = {1'b0, ptr_q} + OneW;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (start_ok) begin
          state_d = (load_word_count == '0) ? StChk : StLoad;
        end
      end
      StLoad: begin
        if (last_byte && (ptr_next == count_q)) begin
          state_d = StChk;
        end
      end
      StChk: begin
        if (last_byte) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs
  always_comb begin
    imem_busy       = (state_q != StRun);
    load_byte_ready = (state_q != StRun);
    imem_data       = (state_q == StRun) ? mem[imem_addr] : Nop;
    load_done       = done_q;
    load_error      = err_q;
  end

  // Loader datapath next-state
  always_comb begin
    count_d    = count_q;
    ptr_d      = ptr_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    acc_d      = acc_q;
    err_d      = err_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (start_ok) begin
          count_d    = load_word_count;
          ptr_d      = '0;
          byte_idx_d = '0;
          asm_d      = '0;
          acc_d      = '0;
          err_d      = 1'b0;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end
      StLoad, StChk: begin
        if (last_byte) begin
          byte_idx_d = '0;
          if (state_q == StLoad) begin
            mem_we = 1'b1;
            acc_d  = acc_q ^ word_full;
            // Hold the pointer on the final word so it never passes count-1
            if (ptr_next != count_q) begin
              ptr_d = ptr_q + 1'b1;
            end
          end else begin
            err_d  = (word_full != acc_q);
            done_d = 1'b1;
          end
        end else if (byte_fire) begin
          asm_d[8*byte_idx_q +: 8] = load_byte;
          byte_idx_d               = byte_idx_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      ptr_q      <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Array is not reset; a reset coinciding with a final byte discards that word
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[ptr_q] <= word_full;
    end
  end

endmodule

// File: tb/tb_imem_loader_responder.sv
// Randomized self-checking bench for imem_loader_responder against a transaction-level model
// of the instruction array and the loader's error flag.
module tb_imem_loader_responder;

  localparam int Depth = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        imem_busy;
  logic        load_start;
  logic [10:0] load_word_count;
  logic [7:0]  load_byte;
  logic        load_byte_valid;
  logic        load_byte_ready;
  logic        load_done;
  logic        load_error;

  imem_loader_responder #(
    .DATA_WIDTH      (32),
    .IMEM_DEPTH      (1024),
    .IMEM_ADDR_WIDTH (10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .imem_busy       (imem_busy),
    .load_start      (load_start),
    .load_word_count (load_word_count),
    .load_byte       (load_byte),
    .load_byte_valid (load_byte_valid),
    .load_byte_ready (load_byte_ready),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [31:0] ref_mem   [Depth];
  bit          ref_known [Depth];
  bit          ref_err;

  always @(posedge clk) if (load_done === 1'b1) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte, optionally preceded by idle cycles with valid low.
  task automatic put_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      load_byte_valid = 1'b0;
      load_byte       = 8'($urandom);
      imem_addr       = 10'($urandom);
      @(negedge clk);
      check_val("gap_busy", imem_busy, 1);
      check_val("gap_nop", imem_data, 32'h0000_0013);
      check_val("gap_no_done", load_done, 0);
    end
    load_byte_valid = 1'b1;
    load_byte       = b;
    @(negedge clk);
    load_byte_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
  endfunction

  // gap < 0 selects a random 0..3 idle cycles before each byte.
  task automatic run_load(input int count, input logic [31:0] words[$], input logic [31:0] chk,
                          input int gap);
    logic [31:0] acc;
    logic [31:0] wd;
    int          d0;
    bit          exp_err;
    acc = '0;
    foreach (words[i]) acc ^= words[i];
    exp_err         = (acc != chk);
    d0              = done_cnt;
    load_word_count = 11'(count);
    load_start      = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_val("start_busy", imem_busy, 1);
    check_val("start_ready", load_byte_ready, 1);
    check_val("start_err_clr", load_error, 0);
    for (int w = 0; w < count; w++) begin
      wd = words[w];
      for (int b = 0; b < 4; b++) put_byte(wd[8*b +: 8], pick_gap(gap));
      check_val("word_busy", imem_busy, 1);
    end
    for (int b = 0; b < 4; b++) begin
      put_byte(chk[8*b +: 8], pick_gap(gap));
      if (b < 3) check_val("chk_no_done", load_done, 0);
    end
    check_val("done_pulse", load_done, 1);
    check_val("done_busy", imem_busy, 0);
    check_val("done_ready", load_byte_ready, 0);
    check_val("done_err", load_error, 32'(exp_err));
    for (int w = 0; w < count; w++) begin
      ref_mem[w]   = words[w];
      ref_known[w] = 1'b1;
    end
    ref_err = exp_err;
    @(negedge clk);
    check_val("done_once", load_done, 0);
    check_val("done_count", done_cnt - d0, 1);
    check_val("err_sticky", load_error, 32'(ref_err));
  endtask

  task automatic verify_mem(input int upto);
    for (int a = 0; a < upto; a++) begin
      if (ref_known[a]) begin
        imem_addr = 10'(a);
        #1;
        check_val($sformatf("mem[%0d]", a), imem_data, ref_mem[a]);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] q[$];
    int          d0;
    int          cnt;
    logic [31:0] acc;

    foreach (ref_known[i]) ref_known[i] = 1'b0;
    ref_err         = 1'b0;
    rst             = 1'b1;
    imem_addr       = '0;
    load_start      = 1'b0;
    load_word_count = '0;
    load_byte       = '0;
    load_byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", imem_busy, 0);
    check_val("rst_ready", load_byte_ready, 0);
    check_val("rst_done", load_done, 0);
    check_val("rst_err", load_error, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reference two-word load
    q = {32'h0050_0093, 32'h00A0_0113};
    run_load(2, q, 32'h00F0_0180, 0);
    imem_addr = 10'd0; #1; check_val("prog_w0", imem_data, 32'h0050_0093);
    imem_addr = 10'd1; #1; check_val("prog_w1", imem_data, 32'h00A0_0113);
    @(negedge clk);

    // Bad checksum: error sticky, words kept
    run_load(2, q, 32'h0, 0);
    repeat (4) @(negedge clk);
    check_val("bad_chk_sticky", load_error, 1);
    verify_mem(2);

    // Stalled byte stream
    q = {32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D};
    run_load(3, q, 32'hDEAD_BEEF ^ 32'h1234_5678 ^ 32'h0BAD_F00D, 3);
    verify_mem(3);

    // Oversized count is rejected
    load_word_count = 11'd1025;
    load_start      = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_val("ovf_err", load_error, 1);
    check_val("ovf_busy", imem_busy, 0);
    check_val("ovf_ready", load_byte_ready, 0);
    for (int i = 0; i < 4; i++) put_byte(8'hFF, 0);
    check_val("ovf_still_run", imem_busy, 0);
    ref_err = 1'b1;
    verify_mem(3);

    // Reset mid-load after five bytes
    d0              = done_cnt;
    load_word_count = 11'd2;
    load_start      = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    put_byte(8'h11, 0); put_byte(8'h22, 0); put_byte(8'h33, 0); put_byte(8'h44, 0);
    put_byte(8'h55, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_busy", imem_busy, 0);
    check_val("mid_rst_err", load_error, 0);
    check_val("mid_rst_done", load_done, 0);
    @(negedge clk);
    check_val("mid_rst_no_pulse", done_cnt - d0, 0);
    ref_mem[0] = 32'h4433_2211;
    ref_err    = 1'b0;
    verify_mem(3);

    // Reset beats a simultaneous start
    load_word_count = 11'd1;
    load_start      = 1'b1;
    rst             = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    rst        = 1'b0;
    check_val("rst_vs_start", imem_busy, 0);

    // Zero-length load: checksum only
    q = {};
    run_load(0, q, 32'h0, 0);
    verify_mem(3);

    // Randomized loads, some with corrupted checksums
    for (int t = 0; t < 20; t++) begin
      cnt = int'($urandom_range(1, 8));
      q   = {};
      acc = '0;
      for (int i = 0; i < cnt; i++) begin
        q.push_back($urandom);
        acc ^= q[i];
      end
      if ($urandom_range(0, 2) == 0) acc ^= 32'(1) << $urandom_range(0, 31);
      run_load(cnt, q, acc, -1);
      repeat (int'($urandom_range(0, 3))) begin
        @(negedge clk);
        check_val("idle_err", load_error, 32'(ref_err));
      end
      verify_mem(8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
